// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline stall/flush arbiter with illegal-instruction drain and stall watchdog.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
   parameter int NSTAGE        = 5,
   parameter int STALL_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NSTAGE-1:0] stall_req,
   input  logic [NSTAGE-1:0] flush_req,
   input  logic              id_error,
   input  logic [31:0]       id_pc,
   output logic [NSTAGE-1:0] stall,
   output logic [NSTAGE-1:0] flush,
   output logic              halted,
   output logic [1:0]        halt_cause,
   output logic [31:0]       halt_pc,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_events
);
   localparam int IW = $clog2(NSTAGE);
   localparam int WW = $clog2(STALL_TIMEOUT);
   typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
   state_t state, state_nx;
   logic [IW-1:0] f_idx, s_idx, drain_cnt, drain_nx;
   logic [WW-1:0] wd_cnt, wd_nx;
   logic [1:0] cause_nx;
   logic [31:0] pc_nx;
   logic flush_ok, wrong_path;
   logic [NSTAGE-1:0] run_stall, run_flush;
   // Oldest request wins; stall requests from stages being flushed are dropped.
   always_comb begin
      f_idx = '0;
      s_idx = '0;
      for (int i = 0; i < NSTAGE; i++)
         if (flush_req[i]) f_idx = IW'(i);
      for (int i = 0; i < NSTAGE; i++)
         if (stall_req[i] && IW'(i) >= f_idx) s_idx = IW'(i);
      flush_ok = s_idx <= f_idx;
      for (int j = 0; j < NSTAGE; j++) begin
         run_flush[j] = flush_ok && IW'(j) < f_idx;
         run_stall[j] = IW'(j) < s_idx && !run_flush[j];
      end
   end
   assign wrong_path = flush_ok && f_idx >= IW'(2);
   assign halted = state == HALT;
   always_comb begin
      stall = run_stall;
      flush = run_flush;
      if (state == HALT) begin
         stall = '1;
         flush = '0;
      end else if (state == DRAIN && !wrong_path) begin
         stall = {run_stall[NSTAGE-1:2], 2'b01};
         flush = {run_flush[NSTAGE-1:2], 2'b10};
      end
   end
   always_comb begin
      state_nx = state;
      drain_nx = drain_cnt;
      wd_nx    = '0;
      cause_nx = halt_cause;
      pc_nx    = halt_pc;
      case (state)
         RUN:
            if (id_error && !flush[1] && !stall[1]) begin
               pc_nx    = id_pc;
               drain_nx = IW'(NSTAGE-2);
               state_nx = DRAIN;
            end else if (|stall) begin
               if (wd_cnt == WW'(STALL_TIMEOUT-1)) begin
                  state_nx = HALT;
                  cause_nx = 2'b10;
               end else wd_nx = wd_cnt + WW'(1);
            end
         DRAIN:
            // An older flush proves the illegal instruction was on a wrong path.
            if (wrong_path) begin
               pc_nx    = '0;
               state_nx = RUN;
            end else if (stall[NSTAGE-1:2] == '0) begin
               drain_nx = drain_cnt - IW'(1);
               if (drain_cnt == IW'(1)) begin
                  state_nx = HALT;
                  cause_nx = 2'b01;
               end
            end
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= RUN;
         drain_cnt  <= '0;
         wd_cnt     <= '0;
         halt_cause <= '0;
         halt_pc    <= '0;
      end else begin
         state      <= state_nx;
         drain_cnt  <= drain_nx;
         wd_cnt     <= wd_nx;
         halt_cause <= cause_nx;
         halt_pc    <= pc_nx;
      end
   end
`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         stall_cycles <= stall_cycles + (stall[0] ? 32'd1 : 32'd0);
         flush_events <= flush_events + (|flush ? 32'd1 : 32'd0);
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed spec scenarios plus randomized traffic against a mask-arithmetic reference model.
module tb_pipe_ctrl;
   localparam int NS = 5;
   localparam int TO = 4;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n, id_error, halted;
   logic [NS-1:0] stall_req, flush_req, stall, flush;
   logic [31:0] id_pc, halt_pc, stall_cycles, flush_events;
   logic [1:0] halt_cause;
   int checks = 0, errors = 0;
   int m_state, m_drain, m_wd, m_cause, hc;
   logic [31:0] m_pc, m_sc, m_fe;

   pipe_ctrl #(.NSTAGE(NS), .STALL_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush_req(flush_req),
      .id_error(id_error), .id_pc(id_pc), .stall(stall), .flush(flush), .halted(halted),
      .halt_cause(halt_cause), .halt_pc(halt_pc), .stall_cycles(stall_cycles),
      .flush_events(flush_events)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_drain = 0; m_wd = 0; m_cause = 0;
      m_pc = 0; m_sc = 0; m_fe = 0;
   endtask

   // One clock: drive inputs, check every output against the model, then advance the model.
   task automatic cycle(input logic r, input logic [NS-1:0] sr, input logic [NS-1:0] fr,
                        input logic e, input logic [31:0] pc);
      int f, s;
      bit ok, wp;
      logic [NS-1:0] rf, rs, es, ef;
      @(negedge clk);
      rst_n = r; stall_req = sr; flush_req = fr; id_error = e; id_pc = pc;
      #1;
      f = 0;
      for (int i = NS-1; i >= 1; i--) if (fr[i]) begin f = i; break; end
      s = 0;
      for (int i = NS-1; i >= 1; i--) if (sr[i] && i >= f) begin s = i; break; end
      ok = s <= f;
      wp = ok && f >= 2;
      rf = ok ? NS'((1 << f) - 1) : '0;
      rs = NS'((1 << s) - 1) & ~rf;
      if (m_state == 2) begin es = '1; ef = '0; end
      else if (m_state == 1 && !wp) begin
         es = (rs & 5'b11100) | 5'b00001;
         ef = (rf & 5'b11100) | 5'b00010;
      end else begin es = rs; ef = rf; end
      chk("stall", 32'(stall), 32'(es));
      chk("flush", 32'(flush), 32'(ef));
      chk("halted", 32'(halted), 32'(m_state == 2));
      chk("halt_cause", 32'(halt_cause), 32'(m_cause));
      chk("halt_pc", halt_pc, m_pc);
      chk("stall_cycles", stall_cycles, m_sc);
      chk("flush_events", flush_events, m_fe);
      if (!r) model_reset();
      else begin
`ifdef PIPE_CTRL_PERF_EN
         if (es[0]) m_sc++;
         if (ef != 0) m_fe++;
`endif
         if (m_state == 0) begin
            if (e && !ef[1] && !es[1]) begin
               m_pc = pc; m_drain = NS-2; m_state = 1; m_wd = 0;
            end else if (es != 0) begin
               if (m_wd == TO-1) begin m_state = 2; m_cause = 2; end
               else m_wd++;
            end else m_wd = 0;
         end else if (m_state == 1) begin
            if (wp) begin m_state = 0; m_pc = 0; m_wd = 0; end
            else if (es[4:2] == 0) begin
               m_drain--;
               if (m_drain == 0) begin m_state = 2; m_cause = 1; end
            end
         end
      end
   endtask

   initial begin
      logic [NS-1:0] sr, fr;
      logic r;
      rst_n = 0; stall_req = 0; flush_req = 0; id_error = 0; id_pc = 0;
      model_reset();
      repeat (2) @(posedge clk);
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_cause", 32'(halt_cause), 0);
      repeat (3) cycle(1, 5'b00100, 0, 0, 0);
      chk("lu_stall", 32'(stall), 32'h03);
      chk("lu_flush", 32'(flush), 0);
      cycle(1, 0, 0, 0, 0);
      chk("lu_run", 32'(halted), 0);
      cycle(1, 5'b00010, 5'b01000, 0, 0);
      chk("br_flush", 32'(flush), 32'h07);
      chk("br_stall", 32'(stall), 0);
      cycle(1, 5'b10000, 5'b01000, 0, 0);
      chk("wb_stall", 32'(stall), 32'h0f);
      chk("wb_flush", 32'(flush), 0);
      cycle(1, 0, 0, 1, 32'h80);
      repeat (3) cycle(1, 0, 0, 0, 0);
      chk("drain_stall", 32'(stall), 32'h01);
      chk("drain_flush", 32'(flush), 32'h02);
      cycle(1, 0, 0, 0, 0);
      chk("ill_halted", 32'(halted), 1);
      chk("ill_cause", 32'(halt_cause), 1);
      chk("ill_pc", halt_pc, 32'h80);
      chk("ill_stall", 32'(stall), 32'h1f);
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("hrst_halted", 32'(halted), 0);
      chk("hrst_pc", halt_pc, 0);
      chk("hrst_sc", stall_cycles, 0);
      cycle(1, 0, 0, 1, 32'h44);
      cycle(1, 0, 5'b01000, 0, 0);
      chk("wp_flush", 32'(flush), 32'h07);
      cycle(1, 0, 0, 0, 0);
      chk("wp_halted", 32'(halted), 0);
      chk("wp_pc", halt_pc, 0);
      cycle(1, 5'b00100, 0, 0, 0);
      chk("wp_run_stall", 32'(stall), 32'h03);
      cycle(1, 0, 0, 0, 0);
      repeat (4) cycle(1, 5'b01000, 0, 0, 0);
      chk("wd_pre", 32'(halted), 0);
      cycle(1, 0, 0, 0, 0);
      chk("wd_halted", 32'(halted), 1);
      chk("wd_cause", 32'(halt_cause), 2);
      cycle(0, 0, 0, 0, 0);
      hc = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < NS; b++) begin
            sr[b] = $urandom_range(0, 5) == 0;
            fr[b] = $urandom_range(0, 7) == 0;
         end
         hc = m_state == 2 ? hc + 1 : 0;
         r = !(hc >= 3) && $urandom_range(0, 59) != 0;
         cycle(r, sr, fr, $urandom_range(0, 5) == 0, $urandom);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
